// File: rtl/wc_pkg.sv
// Shared constants and types for the Winograd tile loader.
// Geometry of the input tile and the loader FSM encoding.
package wc_pkg;

  localparam int DW      = 8;
  localparam int N_IN    = 10;
  localparam int OVERLAP = 4;
  localparam int STRIDE  = N_IN - OVERLAP;
  localparam int IDXW    = 8;
  localparam int CW      = $clog2(N_IN + 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

endpackage

// File: rtl/wc_tile_loader.sv
// Byte-serial to overlapping-tile loader feeding the Winograd core.
// Samples fill a window; full or row-terminated windows are held as a tile.
module wc_tile_loader
  import wc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [N_IN*DW-1:0]   tile_data,
  output logic                 tile_last,
  output logic [IDXW-1:0]      tile_idx
);

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [N_IN-1:0][DW-1:0]     win_q, win_d;
  logic                        row_end_q, row_end_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        live_q;
  logic                        accept;

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready   = live_q & (state_q == FILL);
  assign tile_valid = (state_q == HOLD);
  assign tile_data  = win_q;
  assign tile_last  = row_end_q;
  assign tile_idx   = idx_q;
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    row_end_d = row_end_q;
    idx_d     = idx_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          win_d[cnt_q] = in_data;
          cnt_d        = cnt_q + CW'(1);
          if (in_last || cnt_q == CW'(N_IN - 1)) begin
            state_d   = HOLD;
            row_end_d = in_last;
          end
        end
      end
      HOLD: begin
        if (tile_ready) begin
          state_d = FILL;
          if (row_end_q) begin
            win_d     = '0;
            cnt_d     = '0;
            idx_d     = '0;
            row_end_d = 1'b0;
          end else begin
            // slide: element k takes k+STRIDE, top positions zero-fill
            win_d = win_q >> (STRIDE * DW);
            cnt_d = CW'(OVERLAP);
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      win_q     <= '0;
      row_end_q <= 1'b0;
      idx_q     <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      row_end_q <= row_end_d;
      idx_q     <= idx_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wc_tile_loader.sv
// Directed bench for wc_tile_loader.
// Each scenario task drives rows and checks tiles inline.
module tb_wc_tile_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        tile_valid;
  logic        tile_ready;
  logic [79:0] tile_data;
  logic        tile_last;
  logic [7:0]  tile_idx;

  int errors = 0;
  int checks = 0;

  wc_tile_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .tile_last  (tile_last),
    .tile_idx   (tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout in_ready=%b required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_tile(output logic [79:0] d, output logic l,
                          output logic [7:0] idx, output logic to);
    int n;
    n = 0;
    while (!tile_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    to  = (tile_valid !== 1'b1);
    d   = tile_data;
    l   = tile_last;
    idx = tile_idx;
    tile_ready = 1'b1;
    @(posedge clk); #1;
    tile_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({in_ready, tile_valid, tile_last} !== 3'b000 ||
        tile_data !== 80'h0 || tile_idx !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs rdy/vld/last=%b%b%b data=%h idx=%h required zero",
               in_ready, tile_valid, tile_last, tile_data, tile_idx);
    end
    #10;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready got=%b required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got=%b required 1", in_ready);
    end
  endtask

  task automatic test_full_row();
    logic [79:0] d, exp;
    logic l, to;
    logic [7:0] idx;
    for (int k = 0; k < 10; k++) exp[k*8 +: 8] = 8'(k + 1);
    for (int k = 1; k <= 10; k++) push(8'(k), k == 10);
    checks++;
    if (tile_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL t1_tile_cycle valid=%b ready=%b required 1 0",
               tile_valid, in_ready);
    end
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b1 || idx !== 8'd0) begin
      errors++;
      $display("FAIL t1_tile to=%b data=%h last=%b idx=%0d required %h 1 0",
               to, d, l, idx, exp);
    end
  endtask

  task automatic test_slide();
    logic [79:0] d, exp;
    logic l, to;
    logic [7:0] idx;
    for (int k = 0; k < 10; k++) exp[k*8 +: 8] = 8'(k + 1);
    for (int k = 1; k <= 10; k++) push(8'(k), 1'b0);
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b0 || idx !== 8'd0) begin
      errors++;
      $display("FAIL t2_tile0 to=%b data=%h last=%b idx=%0d required %h 0 0",
               to, d, l, idx, exp);
    end
    for (int k = 11; k <= 15; k++) push(8'(k), 1'b0);
    checks++;
    if (tile_valid !== 1'b0) begin
      errors++;
      $display("FAIL t2_early_tile valid=%b required 0", tile_valid);
    end
    push(8'd16, 1'b1);
    checks++;
    if (tile_valid !== 1'b1) begin
      errors++;
      $display("FAIL t2_six_accepts valid=%b required 1", tile_valid);
    end
    for (int k = 0; k < 10; k++) exp[k*8 +: 8] = 8'(k + 7);
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b1 || idx !== 8'd1) begin
      errors++;
      $display("FAIL t2_tile1 to=%b data=%h last=%b idx=%0d required %h 1 1",
               to, d, l, idx, exp);
    end
  endtask

  task automatic test_partial_slide();
    logic [79:0] d, exp;
    logic l, to;
    logic [7:0] idx;
    for (int k = 1; k <= 10; k++) push(8'(k), 1'b0);
    get_tile(d, l, idx, to);
    for (int k = 11; k <= 13; k++) push(8'(k), k == 13);
    exp = '0;
    for (int k = 0; k < 7; k++) exp[k*8 +: 8] = 8'(k + 7);
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b1 || idx !== 8'd1) begin
      errors++;
      $display("FAIL t3_tile1 to=%b data=%h last=%b idx=%0d required %h 1 1",
               to, d, l, idx, exp);
    end
  endtask

  task automatic test_short_row();
    logic [79:0] d, exp;
    logic l, to;
    logic [7:0] idx;
    for (int k = 1; k <= 3; k++) push(8'(k), k == 3);
    exp = 80'h0302_01;
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b1 || idx !== 8'd0) begin
      errors++;
      $display("FAIL t4_short to=%b data=%h last=%b idx=%0d required %h 1 0",
               to, d, l, idx, exp);
    end
    for (int k = 21; k <= 30; k++) push(8'(k), k == 30);
    for (int k = 0; k < 10; k++) exp[k*8 +: 8] = 8'(k + 21);
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b1 || idx !== 8'd0) begin
      errors++;
      $display("FAIL t4_next_row to=%b data=%h last=%b idx=%0d required %h 1 0",
               to, d, l, idx, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [79:0] d, exp;
    logic l, to;
    logic [7:0] idx;
    for (int k = 0; k < 10; k++) exp[k*8 +: 8] = 8'(k + 1);
    for (int k = 1; k <= 10; k++) push(8'(k), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (tile_valid !== 1'b1 || in_ready !== 1'b0 || tile_data !== exp ||
          tile_last !== 1'b0 || tile_idx !== 8'd0) begin
        errors++;
        $display("FAIL t5_hold c=%0d vld=%b rdy=%b data=%h last=%b idx=%0d required 1 0 %h 0 0",
                 c, tile_valid, in_ready, tile_data, tile_last, tile_idx, exp);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    get_tile(d, l, idx, to);
    for (int k = 11; k <= 16; k++) push(8'(k), k == 16);
    for (int k = 0; k < 10; k++) exp[k*8 +: 8] = 8'(k + 7);
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b1 || idx !== 8'd1) begin
      errors++;
      $display("FAIL t5_tile1 to=%b data=%h last=%b idx=%0d required %h 1 1",
               to, d, l, idx, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [79:0] d, exp;
    logic l, to;
    logic [7:0] idx;
    for (int k = 1; k <= 4; k++) push(8'(k), 1'b0);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (tile_data !== 80'h0 || in_ready !== 1'b0 || tile_valid !== 1'b0 ||
        tile_idx !== 8'h0 || tile_last !== 1'b0) begin
      errors++;
      $display("FAIL t6_async_clear data=%h rdy=%b vld=%b idx=%0d last=%b required zero",
               tile_data, in_ready, tile_valid, tile_idx, tile_last);
    end
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) exp[k*8 +: 8] = 8'(k + 1);
    for (int k = 1; k <= 10; k++) push(8'(k), k == 10);
    get_tile(d, l, idx, to);
    checks++;
    if (to || d !== exp || l !== 1'b1 || idx !== 8'd0) begin
      errors++;
      $display("FAIL t6_clean_tile to=%b data=%h last=%b idx=%0d required %h 1 0",
               to, d, l, idx, exp);
    end
  endtask

  initial begin
    in_valid   = 1'b0;
    in_data    = 8'h0;
    in_last    = 1'b0;
    tile_ready = 1'b0;
    test_reset();
    test_full_row();
    test_slide();
    test_partial_slide();
    test_short_row();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
